// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and fixed sideband values for the command-driven master.
package ahb_lite_pkg;

  // Transfer types. This master only ever drives IDLE or NONSEQ.
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  // Transfer sizes supported on a 32-bit data bus.
  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Fixed sideband: single transfers, privileged data access, never locked.
  localparam logic [2:0] HBURST_SINGLE   = 3'b000;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

endpackage

// File: rtl/ahb_lite_master.sv
// AHB-Lite master bridging a valid/ready command port to single bus transfers.
// Pipeline: one address phase plus one data phase in flight; responses in order.
// A two-cycle ERROR cancels the pending address phase; both transfers report an error.
module ahb_lite_master
  import ahb_lite_pkg::*;
#(
  parameter int ID_W = 4
) (
  input  logic            HCLK,
  input  logic            HRESET,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [31:0]     cmd_addr,
  input  logic [2:0]      cmd_size,
  input  logic [31:0]     cmd_wdata,
  input  logic [ID_W-1:0] cmd_id,
  output logic            rsp_valid,
  output logic [31:0]     rsp_rdata,
  output logic            rsp_error,
  output logic [ID_W-1:0] rsp_id,
  output logic [31:0]     HADDR,
  output logic [1:0]      HTRANS,
  output logic            HWRITE,
  output logic [2:0]      HSIZE,
  output logic [2:0]      HBURST,
  output logic [3:0]      HPROT,
  output logic            HMASTLOCK,
  output logic [31:0]     HWDATA,
  input  logic            HREADY,
  input  logic            HRESP,
  input  logic [31:0]     HRDATA
);

  // Address phase
  htrans_e         htrans_q;
  logic [31:0]     haddr_q;
  logic            hwrite_q;
  logic [2:0]      hsize_q;
  logic [31:0]     ap_wdata_q;
  logic [ID_W-1:0] ap_id_q;

  // Data phase
  logic            dp_valid_q;
  logic            dp_write_q;
  logic [ID_W-1:0] dp_id_q;
  logic [31:0]     hwdata_q;

  // Response port
  logic            rsp_valid_q;
  logic [31:0]     rsp_rdata_q;
  logic            rsp_error_q;
  logic [ID_W-1:0] rsp_id_q;

  // Error bookkeeping: err_hold blocks new commands between the two ERROR cycles;
  // the cancelled address-phase command waits in cxl_* for its error response.
  logic            err_hold_q;
  logic            cxl_valid_q;
  logic [ID_W-1:0] cxl_id_q;

  logic ap_valid;
  logic pipe_empty;
  logic misaligned;
  logic cmd_fire;

  assign ap_valid   = (htrans_q == HTRANS_NONSEQ);
  assign pipe_empty = !ap_valid && !dp_valid_q && !cxl_valid_q;

  // Alignment check on the incoming command.
  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    misaligned = 1'b1;
    unique case (cmd_size)
      HSIZE_BYTE: misaligned = 1'b0;
      HSIZE_HALF: misaligned = cmd_addr[0];
      HSIZE_WORD: misaligned = |cmd_addr[1:0];
      default:    misaligned = 1'b1;
    endcase
  end

  // Misaligned commands never reach the bus, so they only enter an empty pipeline
  // where their immediate error response cannot collide with a bus response.
  assign cmd_ready = !HRESET && HREADY && !err_hold_q && (!misaligned || pipe_empty);
  assign cmd_fire  = cmd_valid && cmd_ready;

  // Bus pipeline, response generation and error handling.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      htrans_q    <= HTRANS_IDLE;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hsize_q     <= '0;
      ap_wdata_q  <= '0;
      ap_id_q     <= '0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_id_q     <= '0;
      hwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      rsp_id_q    <= '0;
      err_hold_q  <= 1'b0;
      cxl_valid_q <= 1'b0;
      cxl_id_q    <= '0;
    end else begin
      rsp_valid_q <= 1'b0;

      // Cancelled command reports one cycle after the erroring transfer.
      if (cxl_valid_q && !err_hold_q) begin
        rsp_valid_q <= 1'b1;
        rsp_error_q <= 1'b1;
        rsp_rdata_q <= '0;
        rsp_id_q    <= cxl_id_q;
        cxl_valid_q <= 1'b0;
      end

      if (HREADY) begin
        err_hold_q <= 1'b0;

        // Data phase completes (HRESP here is the second ERROR cycle).
        if (dp_valid_q) begin
          rsp_valid_q <= 1'b1;
          rsp_id_q    <= dp_id_q;
          rsp_error_q <= HRESP;
          rsp_rdata_q <= (dp_write_q || HRESP) ? '0 : HRDATA;
        end

        // Address phase advances into the data phase.
        dp_valid_q <= ap_valid;
        dp_write_q <= hwrite_q;
        dp_id_q    <= ap_id_q;
        hwdata_q   <= ap_wdata_q;

        if (cmd_fire && !misaligned) begin
          htrans_q   <= HTRANS_NONSEQ;
          haddr_q    <= cmd_addr;
          hwrite_q   <= cmd_write;
          hsize_q    <= cmd_size;
          ap_wdata_q <= cmd_wdata;
          ap_id_q    <= cmd_id;
        end else begin
          htrans_q <= HTRANS_IDLE;
        end

        if (cmd_fire && misaligned) begin
          rsp_valid_q <= 1'b1;
          rsp_error_q <= 1'b1;
          rsp_rdata_q <= '0;
          rsp_id_q    <= cmd_id;
        end
      end else if (HRESP && dp_valid_q) begin
        // First ERROR cycle: drop the pending address phase, remember its tag.
        htrans_q   <= HTRANS_IDLE;
        err_hold_q <= 1'b1;
        if (ap_valid) begin
          cxl_valid_q <= 1'b1;
          cxl_id_q    <= ap_id_q;
        end
      end
    end
  end

  assign HTRANS    = htrans_q;
  assign HADDR     = haddr_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HWDATA    = hwdata_q;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_DATA_PRIV;
  assign HMASTLOCK = 1'b0;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
  assign rsp_id    = rsp_id_q;

endmodule
